// File: rtl/updown_seq_monitor.sv
// Sequence monitor for an up/down counter: recovers the count direction from
// sampled Q values, declares lock on a consistent run and flags illegal steps.
module updown_seq_monitor #(
    parameter int WIDTH      = 4,
    parameter int LOCK_COUNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] q_in,
    output logic             dir,
    output logic             locked,
    output logic             step_err,
    output logic             dir_change,
    output logic [7:0]       err_count,
    output logic [WIDTH-1:0] last_q
);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        LOCKED
    } state_t;

    localparam logic [3:0] RUN_MAX = 4'(LOCK_COUNT);

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             step_err_q, step_err_d;
    logic             dir_change_q, dir_change_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [WIDTH-1:0] last_q_q, last_q_d;
    logic [3:0]       run_q, run_d;

    logic [WIDTH-1:0] delta;
    logic             is_up, is_down, is_hold, is_step, is_bad;
    logic             step_dir;
    logic [3:0]       run_inc;

    // Modular subtraction makes the wrap steps (max->0, 0->max) legal for free.
    assign delta    = q_in - last_q_q;
    assign is_up    = (delta == WIDTH'(1));
    assign is_down  = (delta == {WIDTH{1'b1}});
    assign is_hold  = (delta == '0);
    assign is_step  = is_up || is_down;
    assign is_bad   = !is_step && !is_hold;
    assign step_dir = is_down;
    assign run_inc  = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 4'd1;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        locked_d     = locked_q;
        step_err_d   = 1'b0;
        dir_change_d = 1'b0;
        err_count_d  = err_count_q;
        last_q_d     = last_q_q;
        run_d        = run_q;

        if (sample_en) begin
            last_q_d = q_in;
            case (state_q)
                IDLE: begin
                    run_d   = 4'd0;
                    state_d = HUNT;
                end
                HUNT: begin
                    if (is_step) begin
                        if (run_q != 4'd0 && step_dir == dir_q) begin
                            run_d = run_inc;
                        end else begin
                            dir_d = step_dir;
                            run_d = 4'd1;
                        end
                        if (run_d >= RUN_MAX) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else if (is_bad) begin
                        run_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // A reversal while locked is a legal mode switch, not an error.
                    if (is_step) begin
                        if (step_dir != dir_q) begin
                            dir_d        = step_dir;
                            dir_change_d = 1'b1;
                        end
                    end else if (is_bad) begin
                        step_err_d = 1'b1;
                        if (err_count_q != 8'hFF) begin
                            err_count_d = err_count_q + 8'd1;
                        end
                        locked_d = 1'b0;
                        run_d    = 4'd0;
                        state_d  = HUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            locked_q     <= 1'b0;
            step_err_q   <= 1'b0;
            dir_change_q <= 1'b0;
            err_count_q  <= 8'd0;
            last_q_q     <= '0;
            run_q        <= 4'd0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            locked_q     <= locked_d;
            step_err_q   <= step_err_d;
            dir_change_q <= dir_change_d;
            err_count_q  <= err_count_d;
            last_q_q     <= last_q_d;
            run_q        <= run_d;
        end
    end

    assign dir        = dir_q;
    assign locked     = locked_q;
    assign step_err   = step_err_q;
    assign dir_change = dir_change_q;
    assign err_count  = err_count_q;
    assign last_q     = last_q_q;

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Self-checking bench for updown_seq_monitor: directed scenarios plus a
// randomized run compared against a behavioural model of the sequence rules.
module tb_updown_seq_monitor;

    localparam int W   = 4;
    localparam int LC  = 2;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         sample_en;
    logic [W-1:0] q_in;
    logic         dir, locked, step_err, dir_change;
    logic [7:0]   err_count;
    logic [W-1:0] last_q;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit       m_seen;
    bit       m_locked;
    bit       m_dir;
    bit       m_se;
    bit       m_dc;
    int       m_run;
    int       m_err;
    int       m_last;

    updown_seq_monitor #(.WIDTH(W), .LOCK_COUNT(LC)) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .q_in       (q_in),
        .dir        (dir),
        .locked     (locked),
        .step_err   (step_err),
        .dir_change (dir_change),
        .err_count  (err_count),
        .last_q     (last_q)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_seen = 0; m_locked = 0; m_dir = 0; m_se = 0; m_dc = 0;
        m_run = 0; m_err = 0; m_last = 0;
    endfunction

    function automatic void model_sample(input int q);
        int  d;
        bit  sdir;
        m_se = 0;
        m_dc = 0;
        if (!m_seen) begin
            m_seen = 1;
            m_run  = 0;
            m_last = q;
            return;
        end
        d    = (q - m_last + MOD) % MOD;
        sdir = (d == MOD - 1);
        if (d == 1 || d == MOD - 1) begin
            if (m_locked) begin
                if (sdir != m_dir) begin m_dir = sdir; m_dc = 1; end
            end else begin
                if (m_run > 0 && sdir == m_dir) m_run = (m_run + 1 > LC) ? LC : m_run + 1;
                else begin m_dir = sdir; m_run = 1; end
                if (m_run >= LC) m_locked = 1;
            end
        end else if (d != 0) begin
            if (m_locked) begin
                m_se = 1;
                if (m_err < 255) m_err++;
                m_locked = 0;
            end
            m_run = 0;
        end
        m_last = q;
    endfunction

    task automatic apply(input int q, input bit en);
        @(negedge clk);
        sample_en = en;
        q_in      = W'(q % MOD);
        @(posedge clk);
        #1;
        if (en) model_sample(q % MOD);
        else begin m_se = 0; m_dc = 0; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        sample_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (dir !== 1'b0)        begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
        checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        checks++; if (step_err !== 1'b0)   begin errors++; $display("FAIL reset_step_err: got %b expected 0", step_err); end
        checks++; if (dir_change !== 1'b0) begin errors++; $display("FAIL reset_dir_change: got %b expected 0", dir_change); end
        checks++; if (err_count !== 8'd0)  begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        checks++; if (last_q !== 4'd0)     begin errors++; $display("FAIL reset_last_q: got %0d expected 0", last_q); end
        $display("test_reset done");
    endtask

    task automatic test_lock_up();
        int seq[4] = '{0, 1, 2, 3};
        int wrap[4] = '{14, 15, 0, 1};
        do_reset();
        foreach (seq[i]) begin
            apply(seq[i], 1'b1);
            checks++; if (locked !== (i >= 2)) begin errors++; $display("FAIL lock_up_locked[%0d]: got %b expected %b", i, locked, (i >= 2)); end
            checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL lock_up_step_err[%0d]: got %b expected 0", i, step_err); end
        end
        checks++; if (dir !== 1'b0)    begin errors++; $display("FAIL lock_up_dir: got %b expected 0", dir); end
        checks++; if (last_q !== 4'd3) begin errors++; $display("FAIL lock_up_last_q: got %0d expected 3", last_q); end
        do_reset();
        apply(11, 1'b1); apply(12, 1'b1); apply(13, 1'b1);
        foreach (wrap[i]) begin
            apply(wrap[i], 1'b1);
            checks++; if (locked !== 1'b1 || dir !== 1'b0 || err_count !== 8'd0)
                begin errors++; $display("FAIL up_wrap[%0d]: got locked=%b dir=%b err=%0d expected 1 0 0", i, locked, dir, err_count); end
        end
        $display("test_lock_up done");
    endtask

    task automatic test_lock_down();
        int seq[5] = '{3, 2, 1, 0, 15};
        do_reset();
        foreach (seq[i]) begin
            apply(seq[i], 1'b1);
            checks++; if (locked !== (i >= 2)) begin errors++; $display("FAIL lock_down_locked[%0d]: got %b expected %b", i, locked, (i >= 2)); end
            if (i >= 1) begin
                checks++; if (dir !== 1'b1) begin errors++; $display("FAIL lock_down_dir[%0d]: got %b expected 1", i, dir); end
            end
            checks++; if (step_err !== 1'b0) begin errors++; $display("FAIL lock_down_step_err[%0d]: got %b expected 0", i, step_err); end
        end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL lock_down_err_count: got %0d expected 0", err_count); end
        $display("test_lock_down done");
    endtask

    task automatic test_dir_change();
        do_reset();
        apply(3, 1'b1); apply(4, 1'b1); apply(5, 1'b1);
        apply(4, 1'b1);
        checks++; if (dir_change !== 1'b1 || dir !== 1'b1 || locked !== 1'b1)
            begin errors++; $display("FAIL dir_change_pulse: got dc=%b dir=%b locked=%b expected 1 1 1", dir_change, dir, locked); end
        apply(3, 1'b1);
        checks++; if (dir_change !== 1'b0 || dir !== 1'b1)
            begin errors++; $display("FAIL dir_change_clear: got dc=%b dir=%b expected 0 1", dir_change, dir); end
        apply(3, 1'b1);
        checks++; if (dir_change !== 1'b0 || dir !== 1'b1 || locked !== 1'b1 || step_err !== 1'b0 || last_q !== 4'd3)
            begin errors++; $display("FAIL dir_change_hold: got dc=%b dir=%b locked=%b se=%b last=%0d expected 0 1 1 0 3",
                                     dir_change, dir, locked, step_err, last_q); end
        $display("test_dir_change done");
    endtask

    task automatic test_bad_step();
        int v;
        int exp;
        do_reset();
        apply(3, 1'b1); apply(4, 1'b1); apply(5, 1'b1);
        apply(9, 1'b1);
        checks++; if (step_err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0 || last_q !== 4'd9)
            begin errors++; $display("FAIL bad_step: got se=%b err=%0d locked=%b last=%0d expected 1 1 0 9",
                                     step_err, err_count, locked, last_q); end
        apply(10, 1'b1);
        checks++; if (step_err !== 1'b0 || locked !== 1'b0)
            begin errors++; $display("FAIL bad_step_clear: got se=%b locked=%b expected 0 0", step_err, locked); end
        apply(11, 1'b1);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL bad_relock: got %b expected 1", locked); end
        v = 11;
        for (int i = 0; i < 260; i++) begin
            v = v + 7;
            apply(v, 1'b1);
            exp = (i + 2 > 255) ? 255 : i + 2;
            checks++; if (err_count !== 8'(exp))
                begin errors++; $display("FAIL err_sat[%0d]: got %0d expected %0d", i, err_count, exp); end
            apply(v + 1, 1'b1); apply(v + 2, 1'b1);
            v = v + 2;
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_sat_final: got %0d expected 255", err_count); end
        $display("test_bad_step done");
    endtask

    task automatic test_async_reset();
        do_reset();
        apply(3, 1'b1); apply(4, 1'b1); apply(5, 1'b1); apply(6, 1'b1);
        apply(12, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({dir, locked, step_err, dir_change} !== 4'b0 || err_count !== 8'd0 || last_q !== 4'd0)
            begin errors++; $display("FAIL async_reset: got dir=%b locked=%b se=%b dc=%b err=%0d last=%0d expected all 0",
                                     dir, locked, step_err, dir_change, err_count, last_q); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply(7, 1'b1);
        checks++; if (step_err !== 1'b0 || locked !== 1'b0 || last_q !== 4'd7)
            begin errors++; $display("FAIL post_reset_first: got se=%b locked=%b last=%0d expected 0 0 7", step_err, locked, last_q); end
        $display("test_async_reset done");
    endtask

    task automatic test_random();
        bit rdir = 0;
        int k;
        int q;
        bit en;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) rdir = ~rdir;
            en = ($urandom_range(0, 5) != 0);
            k  = $urandom_range(0, 9);
            if (k < 6)       q = rdir ? m_last + MOD - 1 : m_last + 1;
            else if (k == 6) q = m_last + MOD - (rdir ? 1 : MOD - 1);
            else if (k == 7) q = m_last;
            else             q = $urandom_range(0, MOD - 1);
            apply(q, en);
            checks++;
            if (dir !== m_dir || locked !== m_locked || step_err !== m_se || dir_change !== m_dc ||
                err_count !== 8'(m_err) || last_q !== W'(m_last)) begin
                errors++;
                $display("FAIL random[%0d]: got dir=%b lk=%b se=%b dc=%b err=%0d last=%0d expected %b %b %b %b %0d %0d",
                         i, dir, locked, step_err, dir_change, err_count, last_q,
                         m_dir, m_locked, m_se, m_dc, m_err, m_last);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        q_in      = '0;
        model_reset();
        test_reset();
        test_lock_up();
        test_lock_down();
        test_dir_change();
        test_bad_step();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_seq_monitor.md
Name: updown_seq_monitor

Overview:
- Receive-side companion to the team's T-flip-flop up/down counter.
- Samples the counter's Q bus and infers the count direction, equivalent to recovering mode M.
- Declares lock once the sequence is consistent and flags illegal transitions.
- Sits beside the counter in test benches and in integrated designs as a self-checking sequence monitor.

Parameters:
- WIDTH, 4, width of the observed count bus.
- LOCK_COUNT, 2, consecutive same-direction steps needed to assert lock (legal range 1..15).

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- sample_en  input  1  qualifies q_in for one clk cycle; q_in is ignored when low.
- q_in  input  WIDTH  observed counter value.
- dir  output  1  inferred direction: 0 = up, 1 = down (same encoding as M).
- locked  output  1  sequence consistent with dir.
- step_err  output  1  one-cycle pulse on an illegal transition.
- dir_change  output  1  one-cycle pulse when a locked sequence reverses.
- err_count  output  8  saturating count of step_err events.
- last_q  output  WIDTH  most recent accepted sample.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - dir, locked, step_err, dir_change = 0.
  - err_count = 0, last_q = 0.
  - Internal run counter = 0.
- Register and update rules:
  - All outputs are registered.
  - Every update occurs on the posedge where sample_en = 1; results are visible the following cycle.
  - step_err and dir_change are high for exactly one cycle, then return to 0 unless re-triggered.
- Step classification, computed on each sample relative to last_q:
  - delta = (q_in - last_q) mod 2^WIDTH.
  - delta = 1 is UP.
  - delta = 2^WIDTH-1 is DOWN.
  - delta = 0 is HOLD.
  - Any other delta is BAD.
  - Wrap-around is legal: for WIDTH=4, 15->0 is UP and 0->15 is DOWN.
- last_q is loaded with q_in on every sample, including BAD samples.
- FSM states: IDLE, HUNT, LOCKED.
- IDLE: the first sample loads last_q, sets run = 0 and moves to HUNT. No classification is made.
- HUNT:
  - UP/DOWN matching the candidate dir: run++.
  - UP/DOWN opposite the candidate dir (or when run = 0): dir = new direction, run = 1.
  - When run reaches LOCK_COUNT: move to LOCKED and set locked = 1 on that same update.
  - BAD: run = 0, no step_err (errors are reported only while locked).
  - HOLD: no change.
- LOCKED:
  - Step in dir: no change.
  - Step opposite dir: dir toggles, dir_change pulses, stay LOCKED. This is a legal mode switch.
  - BAD: step_err pulses, err_count++ (saturates at 255), locked = 0, run = 0, go to HUNT.
  - HOLD: no change.
- The run counter saturates at LOCK_COUNT.
- sample_en low: all state is held and pulses clear.
- Reset mid-operation discards history; the next sample is treated as a first sample.

Test Plan:
1. Reset, then samples 0, 1, 2, 3 -> locked = 1 the cycle after sample 2; dir = 0; step_err never asserted; last_q = 3.
2. Locked up, samples 14, 15, 0, 1 -> locked stays 1; dir = 0; err_count = 0 (up wrap is legal).
3. Reset, then samples 3, 2, 1, 0, 15 -> dir = 1 and locked = 1 after sample 1; down wrap 0->15 gives no error.
4. Locked up at 5, then samples 4, 3 -> dir_change pulses once the cycle after 4; dir = 1; locked stays 1. Then sample 3 repeated -> HOLD, no change.
5. Locked up at 5, then sample 9 -> step_err one-cycle pulse; err_count = 1; locked = 0. Then samples 10, 11 -> locked = 1 again. Forcing 260 BAD events -> err_count stays at 255.
6. Assert rst asynchronously mid-stream (between clock edges) -> all outputs reach 0 before the next posedge. After release, sample 7 gives no error and locked = 0.
